// File: rtl/dilithium_arb_pkg.sv
// dilithium_arb_pkg: shared state, mode and sizing definitions for the Dilithium core arbiter
package dilithium_arb_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_t;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_KEYGEN = 2'b00;
  localparam mode_t MODE_SIGN   = 2'b01;
  localparam mode_t MODE_VERIFY = 2'b10;
  localparam int MAX_REQ = 4;
endpackage

// File: rtl/dilithium_rr_pick.sv
// dilithium_rr_pick: first set request at or after ptr, wrapping, as one-hot and index
module dilithium_rr_pick
  import dilithium_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_n
    $error("dilithium_rr_pick: N_REQ out of range");
  end
  logic [IDX_W-1:0] j;
  // Scan from farthest to nearest so the nearest candidate is written last
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    any = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = IDX_W'((int'(ptr) + i) % N_REQ);
      if (req[j]) idx = j;
    end
    onehot[idx] = any;
  end
endmodule

// File: rtl/dilithium_core_arbiter.sv
// dilithium_core_arbiter: round-robin job arbiter and stream router in front of one Dilithium core
// Optional watchdog in RUN enabled by DILITHIUM_ARB_TIMEOUT_EN.
module dilithium_core_arbiter
  import dilithium_arb_pkg::*;
#(
  parameter int W = 64,
  parameter int N_REQ = 2,
  parameter int TIMEOUT_CYCLES = 2**22,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_start,
  input  logic [N_REQ*2-1:0] req_mode,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_err,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  input  logic [N_REQ-1:0]   req_valid_i,
  output logic [N_REQ-1:0]   req_ready_i,
  input  logic [N_REQ*W-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_valid_o,
  input  logic [N_REQ-1:0]   req_ready_o,
  output logic [W-1:0]       req_data_o,
  output logic               core_start,
  output logic [1:0]         core_mode,
  input  logic               core_done,
  output logic               core_rst,
  output logic               core_valid_i,
  input  logic               core_ready_i,
  output logic [W-1:0]       core_data_i,
  input  logic               core_valid_o,
  output logic               core_ready_o,
  input  logic [W-1:0]       core_data_o
);
  state_t state;
  logic [IDX_W-1:0] ptr, owner, pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic pick_any, active, to_hit;
  dilithium_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req_start),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .any(pick_any)
  );
  assign active = state == START || state == RUN;
  assign busy = state != IDLE;
  assign core_start = state == START;
  assign req_done = state == RELEASE ? grant : '0;
`ifdef DILITHIUM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic tout;
  assign to_hit = state == RUN && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // tout is high exactly in the RELEASE cycle entered through the watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tout <= 1'b0;
    end else begin
      cnt <= state == RUN ? cnt + 1'b1 : '0;
      tout <= to_hit && !core_done;
    end
  end
  assign req_err = tout ? grant : '0;
  assign core_rst = tout;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
  assign req_err = '0;
  assign core_rst = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      core_mode <= MODE_KEYGEN;
    end else begin
      unique case (state)
        IDLE: if (pick_any) begin
          state <= START;
          grant <= pick_oh;
          owner <= pick_idx;
          core_mode <= req_mode[2*pick_idx +: 2];
        end
        START: state <= RUN;
        RUN: if (core_done || to_hit) state <= RELEASE;
        default: begin
          state <= IDLE;
          grant <= '0;
          ptr <= owner == IDX_W'(N_REQ - 1) ? '0 : owner + 1'b1;
        end
      endcase
    end
  end
  assign core_valid_i = active & req_valid_i[owner];
  assign core_data_i = req_data_i[owner*W +: W];
  assign core_ready_o = active & req_ready_o[owner];
  assign req_ready_i = active ? grant & {N_REQ{core_ready_i}} : '0;
  assign req_valid_o = active ? grant & {N_REQ{core_valid_o}} : '0;
  assign req_data_o = core_data_o;
endmodule
